// File: rtl/ram_peek_pkg.sv
// Shared types and constants for the RAM peek streamer and its byte serializer.
package ram_peek_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, LOAD, SEND} peek_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/ram_peek_streamer_word_serializer.sv
// 32-bit to 8-bit little-endian serializer with valid/ready; valid is held
// from load until the last byte of the word is accepted.
module word_serializer
    import ram_peek_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_word,
    input  logic        i_ready,
    output logic [7:0]  o_data,
    output logic        o_valid,
    output logic        o_last,
    output logic        o_accept
);

    logic [31:0]           r_shreg;
    logic [BYTE_IDX_W-1:0] r_byte_idx;
    logic                  r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg    <= '0;
            r_byte_idx <= '0;
            r_valid    <= 1'b0;
        end else if (i_load) begin
            r_shreg    <= i_word;
            r_byte_idx <= '0;
            r_valid    <= 1'b1;
        end else if (o_accept) begin
            // Index wraps back to 0 after the last byte.
            r_byte_idx <= r_byte_idx + BYTE_IDX_W'(1);
            if (o_last) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid  = r_valid;
    assign o_accept = r_valid && i_ready;
    assign o_last   = (r_byte_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));
    assign o_data   = r_shreg[{r_byte_idx, 3'b000} +: 8];

endmodule

// File: rtl/ram_peek_streamer.sv
// Scans a wrapping window of node RAM through its registered peek port and
// streams each word out as four little-endian bytes.
//
// state | meaning
// IDLE  | waiting for start; zero-length requests only pulse done
// WAIT  | peek address issued, RAM output not yet valid
// LOAD  | capture peek data into serializer, advance peek address
// SEND  | serializer presenting bytes; last accept ends word
module ram_peek_streamer
    import ram_peek_pkg::*;
#(
    parameter int RAM_SIZE = 1024,
    parameter int CNT_W    = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_count,
    output logic [31:0]      peek_addr,
    input  logic [31:0]      peek_data,
    output logic [7:0]       m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy,
    output logic             done
);

    localparam logic [31:0] ADDR_MASK = 32'(RAM_SIZE - 1);

    peek_state_t      r_state;
    logic [31:0]      r_peek_addr;
    logic [CNT_W-1:0] r_remaining;
    logic             r_busy;
    logic             r_done;

    peek_state_t      w_state_nxt;
    logic [31:0]      w_addr_nxt;
    logic [CNT_W-1:0] w_rem_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_load;
    logic             w_accept;
    logic             w_last;
    logic [CNT_W-1:0] w_count_clamped;

    assign w_count_clamped = (word_count > CNT_W'(RAM_SIZE)) ? CNT_W'(RAM_SIZE) : word_count;

    word_serializer u_ser (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_word  (peek_data),
        .i_ready (m_ready),
        .o_data  (m_data),
        .o_valid (m_valid),
        .o_last  (w_last),
        .o_accept(w_accept)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_peek_addr <= '0;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_peek_addr <= w_addr_nxt;
            r_remaining <= w_rem_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_peek_addr;
        w_rem_nxt   = r_remaining;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_count_clamped != '0) begin
                        w_addr_nxt  = base_addr & ADDR_MASK;
                        w_rem_nxt   = w_count_clamped;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = WAIT;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            WAIT: w_state_nxt = LOAD;
            LOAD: begin
                // Next address goes out now so its data is settled by the next LOAD.
                w_load      = 1'b1;
                w_addr_nxt  = (r_peek_addr + 32'd1) & ADDR_MASK;
                w_state_nxt = SEND;
            end
            SEND: begin
                if (w_accept && w_last) begin
                    w_rem_nxt = r_remaining - CNT_W'(1);
                    if (r_remaining == CNT_W'(1)) begin
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = LOAD;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign peek_addr = r_peek_addr;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: doc/ram_peek_streamer.md
# ram_peek_streamer

Read-side initiator for a node RAM's peek port. On `start` it scans a contiguous window of RAM words through the peek address/data pair, accounting for the RAM's one-cycle registered peek latency. It serializes each 32-bit word into a little-endian byte stream with valid/ready handshake. It sits between a node RAM and a byte-oriented sink (UART TX, debug FIFO) and serves as the hardware replacement for simulation-only image dumps.

## Interface
Parameters:
- `RAM_SIZE`, 1024: RAM depth in words; addresses wrap modulo this value (power of two).
- `CNT_W`, 11: width of `word_count`; must hold `RAM_SIZE`.

Ports (clock and reset first):
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `base_addr` in 32: first word address; sampled with `start`.
- `word_count` in CNT_W: number of words; sampled with `start`.
- `peek_addr` out 32: to RAM `peekAddress`; registered.
- `peek_data` in 32: from RAM `peekData`; valid one cycle after `peek_addr` changes.
- `m_data` out 8: stream byte.
- `m_valid` out 1: stream valid.
- `m_ready` in 1: sink ready.
- `busy` out 1: high from the cycle after `start` until `done`.
- `done` out 1: one-cycle completion pulse.

## Operation
- FSM states: IDLE, WAIT, LOAD, SEND.
- IDLE, `start`=1, clamped count > 0:
  - `peek_addr <= base_addr mod RAM_SIZE`
  - latch `remaining <= min(word_count, RAM_SIZE)`
  - go to WAIT
- IDLE, `start`=1, count = 0: `done` pulses on the next cycle, no bytes are emitted, and `busy` stays low.
- WAIT: always lasts exactly 1 cycle (RAM latency), then go to LOAD.
- LOAD:
  - `shreg <= peek_data`
  - `byte_idx <= 0`
  - `m_valid <= 1`
  - `peek_addr <= (peek_addr+1) mod RAM_SIZE`
  - go to SEND
- SEND:
  - `m_data = shreg[8*byte_idx +: 8]`, so byte order is little-endian (bits 7:0 first).
  - On `m_valid && m_ready`, increment `byte_idx`.
  - On the 4th accept, decrement `remaining`. If it becomes 0: `m_valid <= 0`, pulse `done`, go to IDLE. Otherwise `m_valid <= 0` and go to LOAD.
- `m_data` and `m_valid` are stable while `m_valid && !m_ready`. `m_valid` never drops without an accept.
- `start` in any state other than IDLE is ignored, with no queuing.
- Address arithmetic is 32-bit, with the result masked to `RAM_SIZE-1`. A window crossing the top of RAM wraps to 0.

## Timing
- Reset values: `peek_addr`=0, `m_data`=0, `m_valid`=0, `busy`=0, `done`=0, state IDLE, `remaining`=0.
- Reset mid-transfer:
  - Next cycle is IDLE with all outputs at reset values.
  - No `done` is issued and the partial word is discarded.
- Start latency: `start` sampled at edge E0; `peek_addr` valid after E0; `peek_data` valid after E1; `m_valid` high after E2. The first byte is presentable 3 cycles after `start`.
- Throughput with `m_ready` held at 1: 5 cycles per word (4 SEND plus 1 LOAD bubble). N words finish with `done` at cycle 2+5N after `start`.
- The next `peek_addr` is issued in LOAD, which is ≥4 cycles ahead of the next LOAD. `peek_data` is therefore always settled, and no extra WAIT is needed between words.
- `busy` falls in the same cycle `done` is high. A new `start` is accepted in the cycle after `done`.

## Structure
- Shared package `ram_peek_pkg`:
  - state enum `peek_state_t` {IDLE, WAIT, LOAD, SEND}
  - `localparam BYTES_PER_WORD = 4`
- Sub-module `word_serializer`: 32→8 little-endian shift register with valid/ready and a last-byte flag. The FSM owns addressing and counts only.

## Test plan
- Base 0x000, count 2, RAM[0]=0x11223344, RAM[1]=0xAABBCCDD, `m_ready`=1 → bytes 44,33,22,11,DD,CC,BB,AA; first `m_valid` 3 cycles after `start`; `done` at cycle 12.
- Same transfer, `m_ready` toggling 1/0 every cycle → identical byte sequence; `m_data` unchanged across every stalled cycle.
- Base 0x3FE, count 4 → words from addresses 0x3FE, 0x3FF, 0x000, 0x001 in that order.
- `word_count`=0 → `done` pulses 1 cycle after `start`; `m_valid` never rises; `busy` stays 0. `word_count`=2000 → exactly 1024 words are streamed.
- `rst` asserted during the 2nd byte of word 1 → next cycle all outputs are 0 with no `done`; a fresh `start` then streams correctly from its base.
- `start` pulsed while `busy` → ignored; the byte stream and `done` timing are unchanged.
